// File: rtl/uart_frame_sched.sv
// uart_frame_sched: round-robin two-requester sampler that frames each 16-bit sample into bytes for a UART sender.
// Define UART_FRAME_CKSUM_EN to append a modulo-256 checksum byte (5-byte frames instead of 4).
module uart_frame_sched #(
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         BUSY_WAIT = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic [7:0]  uart_data_w,
    output logic        uart_en_w,
    input  logic        uart_tx_flag,
    output logic        busy,
    output logic        tx_err
);
`ifdef UART_FRAME_CKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int CW = $clog2(BUSY_WAIT + 2);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_FIRE, S_WAIT_HI, S_WAIT_LO, S_NEXT} state_t;

    state_t          r_state, w_next;
    logic            r_last, r_ch;
    logic [15:0]     r_sample;
    logic [2:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic            w_g0, w_g1, w_timeout, w_last_byte;
    logic [7:0]      w_byte;

    // Round-robin: on a tie the requester that was not granted last wins.
    assign w_g0        = (r_state == S_ARB) && req0_valid && (!req1_valid || r_last);
    assign w_g1        = (r_state == S_ARB) && req1_valid && !w_g0;
    assign w_timeout   = (r_state == S_WAIT_HI) && !uart_tx_flag && (r_cnt == CW'(BUSY_WAIT));
    assign w_last_byte = r_idx == 3'(NB - 1);

`ifdef UART_FRAME_CKSUM_EN
    logic [7:0] w_cksum;
    assign w_cksum = {7'b0, r_ch} + r_sample[15:8] + r_sample[7:0];
    assign w_byte  = r_idx == 3'd0 ? HEADER :
                     r_idx == 3'd1 ? {7'b0, r_ch} :
                     r_idx == 3'd2 ? r_sample[15:8] :
                     r_idx == 3'd3 ? r_sample[7:0] : w_cksum;
`else
    assign w_byte  = r_idx == 3'd0 ? HEADER :
                     r_idx == 3'd1 ? {7'b0, r_ch} :
                     r_idx == 3'd2 ? r_sample[15:8] : r_sample[7:0];
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = (req0_valid || req1_valid) ? S_ARB : S_IDLE;
            S_ARB:     w_next = (w_g0 || w_g1) ? S_LOAD : S_IDLE;
            S_LOAD:    w_next = S_FIRE;
            S_FIRE:    w_next = S_WAIT_HI;
            S_WAIT_HI: w_next = uart_tx_flag ? S_WAIT_LO : w_timeout ? S_IDLE : S_WAIT_HI;
            S_WAIT_LO: w_next = uart_tx_flag ? S_WAIT_LO : S_NEXT;
            S_NEXT:    w_next = w_last_byte ? S_IDLE : S_LOAD;
            default:   w_next = S_IDLE;
        endcase
    end

    // Byte index only moves in NEXT, so the data bus holds from LOAD through WAIT_LO.
    always_comb begin
        busy        = (r_state != S_IDLE) && (r_state != S_ARB);
        uart_en_w   = r_state == S_FIRE;
        req0_ready  = w_g0;
        req1_ready  = w_g1;
        tx_err      = w_timeout;
        uart_data_w = busy ? w_byte : 8'h00;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last   <= 1'b1;
            r_ch     <= 1'b0;
            r_sample <= 16'h0000;
            r_idx    <= 3'd0;
            r_cnt    <= '0;
        end else begin
            if (w_g0 || w_g1) begin
                r_sample <= w_g1 ? req1_data : req0_data;
                r_ch     <= w_g1;
                r_last   <= w_g1;
                r_idx    <= 3'd0;
            end else if (r_state == S_NEXT) begin
                r_idx    <= r_idx + 3'd1;
            end
            r_cnt <= (r_state == S_WAIT_HI) ? r_cnt + CW'(1) : '0;
        end
    end
endmodule
